// File: rtl/watermark_pkg.sv
// watermark_pkg: shared definitions for the retire-stream watermark extractor.
//   - state_e      : extractor FSM states (IDLE..DONE)
//   - DEFAULT_POLY : default MISR feedback polynomial
//   - DEFAULT_SEED : default signature value loaded on arm
//   - misr_fold()  : one MISR step, shift left with polynomial feedback, then XOR in d
package watermark_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;

  // The bit shifted out of the top selects whether the polynomial is folded back in.
  function automatic logic [31:0] misr_fold(input logic [31:0] sig,
                                            input logic [31:0] d,
                                            input logic [31:0] poly);
    return {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0000_0000) ^ d;
  endfunction

endpackage

// File: rtl/watermark_signature_misr32.sv
// misr32: 32-bit multiple-input signature register.
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset (register returns to SEED)
//   load  in   reload SEED (has priority over en)
//   en    in   fold d into the register this cycle
//   d     in   32-bit data word to fold
//   sig   out  current register value
module misr32
  import watermark_pkg::*;
#(
  parameter logic [31:0] POLY = DEFAULT_POLY,
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] sig
);

  logic [31:0] sig_q;
  logic [31:0] sig_d;

  // Next signature: reload, fold, or hold.
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = misr_fold(sig_q, d, POLY);
    end else begin
      sig_d = sig_q;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/watermark_signature.sv
// watermark_signature: folds a window of WINDOW retired instructions (pc ^ inst),
// starting at the first retire whose PC equals the armed trigger PC, into a MISR
// and compares the result against an expected watermark.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 arm pulse; latches trig_pc and expected, restarts from any state
//   trig_pc, expected     trigger PC and reference watermark
//   ret_valid/pc/inst     retire stream (no backpressure)
//   busy                  registered, high in ARMED, COLLECT, COMPARE
//   done, match           sticky result, match valid while done is high
//   signature, count      current MISR value and retires folded so far
module watermark_signature
  import watermark_pkg::*;
#(
  parameter int          WINDOW = 64,
  parameter logic [31:0] POLY   = DEFAULT_POLY,
  parameter logic [31:0] SEED   = DEFAULT_SEED
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [31:0]                  trig_pc,
  input  logic [31:0]                  expected,
  input  logic                         ret_valid,
  input  logic [31:0]                  ret_pc,
  input  logic [31:0]                  ret_inst,
  output logic                         busy,
  output logic                         done,
  output logic                         match,
  output logic [31:0]                  signature,
  output logic [$clog2(WINDOW+1)-1:0]  count
);

  localparam int            CW  = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] WIN = CW'(WINDOW);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   expected_q, expected_d;
  logic [31:0]   trig_q, trig_d;
  logic          done_q, done_d;
  logic          match_q, match_d;
  logic          busy_q, busy_d;
  logic          load_s;
  logic          fold_s;
  logic [CW-1:0] count_inc_s;
  logic [31:0]   sig_s;

  assign count_inc_s = count_q + ONE;

  misr32 #(
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .en    (fold_s),
    .d     (ret_inst ^ ret_pc),
    .sig   (sig_s)
  );

  // Next-state, counter, latch and result logic. start overrides everything,
  // including a retire presented in the same cycle.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    expected_d = expected_q;
    trig_d     = trig_q;
    done_d     = done_q;
    match_d    = match_q;
    load_s     = 1'b0;
    fold_s     = 1'b0;
    if (start) begin
      state_d    = ST_ARMED;
      count_d    = '0;
      expected_d = expected;
      trig_d     = trig_pc;
      done_d     = 1'b0;
      match_d    = 1'b0;
      load_s     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ARMED: begin
          if (ret_valid && (ret_pc == trig_q)) begin
            fold_s  = 1'b1;
            count_d = ONE;
            state_d = (WINDOW == 1) ? ST_COMPARE : ST_COLLECT;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_COLLECT: begin
          // The trigger PC is only checked once; every later retire is folded.
          if (ret_valid) begin
            fold_s  = 1'b1;
            count_d = count_inc_s;
            if (count_inc_s == WIN) begin
              state_d = ST_COMPARE;
            end else begin
              state_d = ST_COLLECT;
            end
          end else begin
            state_d = ST_COLLECT;
          end
        end
        ST_COMPARE: begin
          match_d = (sig_s == expected_q);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // busy is registered from the next state so it rises the cycle after start.
  always_comb begin
    busy_d = (state_d == ST_ARMED) || (state_d == ST_COLLECT) || (state_d == ST_COMPARE);
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      expected_q <= 32'h0000_0000;
      trig_q     <= 32'h0000_0000;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      expected_q <= expected_d;
      trig_q     <= trig_d;
      done_q     <= done_d;
      match_q    <= match_d;
      busy_q     <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign match     = match_q;
  assign signature = sig_s;
  assign count     = count_q;

endmodule

// File: tb/tb_watermark_signature.sv
module tb_watermark_signature;

  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WINDOW=1 instance (prefix a_)
  logic        a_start, a_rv;
  logic [31:0] a_trig, a_exp, a_pc, a_inst;
  logic        a_busy, a_done, a_match;
  logic [31:0] a_sig;
  logic [0:0]  a_cnt;

  // WINDOW=4 instance (prefix b_)
  logic        b_start, b_rv;
  logic [31:0] b_trig, b_exp, b_pc, b_inst;
  logic        b_busy, b_done, b_match;
  logic [31:0] b_sig;
  logic [2:0]  b_cnt;

  watermark_signature #(.WINDOW(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(a_start), .trig_pc(a_trig), .expected(a_exp),
    .ret_valid(a_rv), .ret_pc(a_pc), .ret_inst(a_inst),
    .busy(a_busy), .done(a_done), .match(a_match), .signature(a_sig), .count(a_cnt)
  );

  watermark_signature #(.WINDOW(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .trig_pc(b_trig), .expected(b_exp),
    .ret_valid(b_rv), .ret_pc(b_pc), .ret_inst(b_inst),
    .busy(b_busy), .done(b_done), .match(b_match), .signature(b_sig), .count(b_cnt)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] sig;
    logic        match;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Reference: multiply the signature by x modulo POLY, then add (xor) the data word.
  function automatic logic [31:0] ref_fold(input logic [31:0] s, input logic [31:0] pc,
                                           input logic [31:0] inst);
    logic [32:0] t;
    t = {s, 1'b0};
    if (t[32]) t[31:0] = t[31:0] ^ POLY;
    return t[31:0] ^ pc ^ inst;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: compare on every rising edge of done.
  logic a_done_prev = 1'b0;
  logic b_done_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (a_done && !a_done_prev) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL w1_unexpected_done actual=1 expected=0");
      end else begin
        e = qa.pop_front();
        chk("w1_sb_sig", a_sig, e.sig);
        chk("w1_sb_match", 32'(a_match), 32'(e.match));
        chk("w1_sb_count", 32'(a_cnt), 32'd1);
      end
    end
    a_done_prev = a_done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_done && !b_done_prev) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL w4_unexpected_done actual=1 expected=0");
      end else begin
        e = qb.pop_front();
        chk("w4_sb_sig", b_sig, e.sig);
        chk("w4_sb_match", 32'(b_match), 32'(e.match));
        chk("w4_sb_count", 32'(b_cnt), 32'd4);
      end
    end
    b_done_prev = b_done;
  end

  // One WINDOW=1 transaction with the trigger retire on the cycle after start.
  task automatic run_w1(input logic [31:0] trig, input logic [31:0] expv,
                        input logic [31:0] pc, input logic [31:0] inst);
    logic [31:0] ms;
    a_trig = trig; a_exp = expv; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("w1_busy_after_start", 32'(a_busy), 32'd1);
    chk("w1_done_cleared", 32'(a_done), 32'd0);
    ms = ref_fold(SEED, pc, inst);
    a_rv = 1'b1; a_pc = pc; a_inst = inst;
    qa.push_back('{sig: ms, match: (ms == expv)});
    tick();
    a_rv = 1'b0;
    chk("w1_sig_after_fold", a_sig, ms);
    chk("w1_not_done_in_compare", 32'(a_done), 32'd0);
    tick();
    chk("w1_done_third_edge", 32'(a_done), 32'd1);
    chk("w1_busy_low_in_done", 32'(a_busy), 32'd0);
  endtask

  // Fold one WINDOW=4 retire and check signature/count against the model.
  task automatic fold_w4(input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] ms_in, input int n, output logic [31:0] ms_out);
    b_rv = 1'b1; b_pc = pc; b_inst = inst;
    tick();
    b_rv = 1'b0;
    ms_out = ref_fold(ms_in, pc, inst);
    chk("w4_count_step", 32'(b_cnt), 32'(n));
    chk("w4_sig_step", b_sig, ms_out);
  endtask

  task automatic wait_b_done(input int lim);
    int n = 0;
    while (!b_done && n < lim) begin
      tick();
      n++;
    end
    chk("w4_done_within_bound", 32'(b_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t, t2, ev, ms, hold;
    logic [31:0] pcs[4];
    logic [31:0] insts[4];

    rst_n = 1'b0;
    a_start = 1'b0; a_rv = 1'b0; a_trig = '0; a_exp = '0; a_pc = '0; a_inst = '0;
    b_start = 1'b0; b_rv = 1'b0; b_trig = '0; b_exp = '0; b_pc = '0; b_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w1_sig", a_sig, SEED);
    chk("rst_w1_count", 32'(a_cnt), 32'd0);
    chk("rst_w4_sig", b_sig, SEED);
    chk("rst_w4_busy", 32'(b_busy), 32'd0);
    chk("rst_w4_done", 32'(b_done), 32'd0);
    chk("rst_w4_match", 32'(b_match), 32'd0);
    rst_n = 1'b1;
    tick();
    // ret_valid in IDLE is ignored.
    b_rv = 1'b1; b_pc = 32'h0; b_inst = 32'h1234_5678;
    tick();
    b_rv = 1'b0;
    chk("idle_ignores_retire", b_sig, SEED);

    // Known-answer vectors, WINDOW=1.
    run_w1(32'h0, 32'hFB3EE249, 32'h0, 32'h0);
    chk("kat1_sig", a_sig, 32'hFB3EE249);
    chk("kat1_match", 32'(a_match), 32'd1);
    run_w1(32'h0, 32'h0, 32'h0, 32'h8C010004);
    chk("kat2_sig", a_sig, 32'h773FE24D);
    chk("kat2_match", 32'(a_match), 32'd0);
    // DONE holds against further retires.
    a_rv = 1'b1;
    repeat (3) begin
      a_pc = $urandom; a_inst = $urandom;
      tick();
    end
    a_rv = 1'b0;
    chk("done_hold_sig", a_sig, 32'h773FE24D);
    chk("done_hold_done", 32'(a_done), 32'd1);

    // Trigger gating, WINDOW=1.
    a_trig = 32'h8; a_exp = $urandom; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_rv = 1'b1; a_pc = 32'h0; a_inst = $urandom;
    tick();
    a_pc = 32'h4; a_inst = $urandom;
    tick();
    a_rv = 1'b0;
    chk("gate_count", 32'(a_cnt), 32'd0);
    chk("gate_sig", a_sig, SEED);
    chk("gate_busy", 32'(a_busy), 32'd1);
    chk("gate_done", 32'(a_done), 32'd0);
    a_rv = 1'b1; a_pc = 32'h8; a_inst = $urandom;
    ms = ref_fold(SEED, a_pc, a_inst);
    qa.push_back('{sig: ms, match: (ms == a_exp)});
    tick();
    a_rv = 1'b0;
    tick();
    chk("gate_done_after_trigger", 32'(a_done), 32'd1);

    // Random WINDOW=1 transactions, alternating matching / random expected.
    for (int i = 0; i < 4; i++) begin
      t = $urandom & 32'hFFFF_FFFC;
      hold = $urandom;
      ev = (i % 2 == 0) ? ref_fold(SEED, t, hold) : $urandom;
      run_w1(t, ev, t, hold);
    end

    // WINDOW=4 with random gaps; decoy retire first; later PCs are arbitrary.
    for (int it = 0; it < 3; it++) begin
      t = $urandom & 32'hFFFF_FFFC;
      pcs[0] = t;
      for (int k = 1; k < 4; k++) pcs[k] = $urandom;
      for (int k = 0; k < 4; k++) insts[k] = $urandom;
      ms = SEED;
      for (int k = 0; k < 4; k++) ms = ref_fold(ms, pcs[k], insts[k]);
      ev = (it == 1) ? $urandom : ms;
      b_trig = t; b_exp = ev; b_start = 1'b1;
      tick();
      b_start = 1'b0;
      chk("w4_busy_after_start", 32'(b_busy), 32'd1);
      chk("w4_done_cleared", 32'(b_done), 32'd0);
      b_rv = 1'b1; b_pc = t ^ 32'h10; b_inst = $urandom;
      tick();
      b_rv = 1'b0;
      chk("w4_decoy_count", 32'(b_cnt), 32'd0);
      hold = SEED;
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        if (k == 3) qb.push_back('{sig: ms, match: (ms == ev)});
        fold_w4(pcs[k], insts[k], hold, k + 1, hold);
      end
      chk("w4_not_done_edge1", 32'(b_done), 32'd0);
      tick();
      chk("w4_done_edge2", 32'(b_done), 32'd1);
      chk("w4_busy_low", 32'(b_busy), 32'd0);
    end

    // start coincident with a retire in COLLECT: the retire is dropped.
    t = $urandom & 32'hFFFF_FFFC;
    t2 = t ^ 32'h100;
    b_trig = t; b_exp = $urandom; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    fold_w4(t, $urandom, SEED, 1, hold);
    fold_w4($urandom, $urandom, hold, 2, hold);
    b_trig = t2; b_start = 1'b1; b_rv = 1'b1; b_pc = t2; b_inst = $urandom;
    tick();
    b_start = 1'b0; b_rv = 1'b0;
    chk("coinc_sig", b_sig, SEED);
    chk("coinc_count", 32'(b_cnt), 32'd0);
    chk("coinc_busy", 32'(b_busy), 32'd1);
    b_rv = 1'b1; b_pc = t2 ^ 32'h4; b_inst = $urandom;
    tick();
    b_rv = 1'b0;
    chk("coinc_still_armed", 32'(b_cnt), 32'd0);
    ms = SEED;
    pcs[0] = t2;
    for (int k = 1; k < 4; k++) pcs[k] = $urandom;
    for (int k = 0; k < 4; k++) insts[k] = $urandom;
    for (int k = 0; k < 4; k++) ms = ref_fold(ms, pcs[k], insts[k]);
    qb.push_back('{sig: ms, match: (ms == b_exp)});
    hold = SEED;
    for (int k = 0; k < 4; k++) fold_w4(pcs[k], insts[k], hold, k + 1, hold);
    wait_b_done(5);

    // start from DONE: done/match fall on the next edge.
    b_trig = 32'h40; b_exp = ms; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("restart_done_low", 32'(b_done), 32'd0);
    chk("restart_match_low", 32'(b_match), 32'd0);

    // Asynchronous reset in the middle of COLLECT.
    fold_w4(32'h40, 32'h1, SEED, 1, hold);
    fold_w4(32'h44, 32'h2, hold, 2, hold);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sig", b_sig, SEED);
    chk("async_rst_count", 32'(b_cnt), 32'd0);
    chk("async_rst_busy", 32'(b_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("after_rst_idle_busy", 32'(b_busy), 32'd0);

    repeat (2) tick();
    chk("w1_scoreboard_drained", 32'(qa.size()), 32'd0);
    chk("w4_scoreboard_drained", 32'(qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watermark_signature.md
# watermark_signature

Retire-stream watermark extractor that sits directly downstream of the single-cycle MIPS core. It samples each retired instruction (PC and instruction word), starting at a trigger PC. It compresses a fixed window of them into a 32-bit multiple-input signature register (MISR), then compares the result against an expected watermark. The result is reported as a sticky `done`/`match` pair for the test harness or host.

## Interface
Parameters:
- `WINDOW`, default 64: number of retired instructions folded into the signature (1..1024).
- `POLY`, default 32'h04C11DB7: MISR feedback polynomial.
- `SEED`, default 32'hFFFFFFFF: signature value loaded on arm.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; arms the extractor and samples `expected` and `trig_pc`.
- `trig_pc`  in  32  PC that opens the collection window.
- `expected`  in  32  reference watermark.
- `ret_valid`  in  1  a retire is presented this cycle; there is no backpressure.
- `ret_pc`  in  32  PC of the retiring instruction.
- `ret_inst`  in  32  instruction word of the retiring instruction.
- `busy`  out  1  high in ARMED, COLLECT and COMPARE.
- `done`  out  1  sticky high in DONE.
- `match`  out  1  valid while `done` is high; 1 when signature equals expected.
- `signature`  out  32  current MISR value.
- `count`  out  $clog2(WINDOW+1)  retires folded so far.

## Operation
- States: IDLE, ARMED, COLLECT, COMPARE, DONE.
- IDLE:
  - `start` -> ARMED.
  - Load `signature`=SEED and `count`=0.
  - Latch `expected` and `trig_pc` into internal registers.
- ARMED:
  - On `ret_valid && ret_pc==trig_q`, fold this retire, set `count`=1, and go to COLLECT.
  - If WINDOW==1, go directly to COMPARE.
- COLLECT:
  - Every `ret_valid` cycle folds one retire and increments `count`.
  - When `count` reaches WINDOW, go to COMPARE.
  - `ret_pc` is not rechecked in this state.
- COMPARE: set `match` = (`signature`==`expected_q`), set `done`=1, go to DONE.
- DONE: hold `signature`, `count`, `match` and `done` until the next `start`.
- Fold, with d = `ret_inst` ^ `ret_pc`:
  - sig_next = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ d.
  - All arithmetic is 32-bit modulo.
  - `count` saturates at WINDOW.
- `start` in any state restarts exactly as from IDLE:
  - Reload SEED, clear `count`, `done` and `match`, re-latch the inputs, go to ARMED.
- `start` and `ret_valid` in the same cycle: `start` wins and the retire is dropped (not folded, not trigger-checked).
- `ret_valid` is ignored in IDLE, COMPARE and DONE.
- Reset values (async on `rst_n` low, including mid-collection):
  - State IDLE, `signature`=SEED, `count`=0, `busy`=0, `done`=0, `match`=0.
  - Latched `expected_q` and `trig_q` = 0.

## Timing
- Fold latency: retire sampled at edge E; the updated `signature`/`count` are visible after E.
- Last fold at edge E -> COMPARE after E; `done`/`match` high after E+1.
- Minimum `start`-to-`done` for WINDOW=1 with the trigger presented on the cycle after `start`: 3 edges.
- `busy` is registered and goes high the cycle after `start`.
- `done` falls the cycle after `start`.
- Gaps in `ret_valid` stall folding without limit; there is no timeout.

## Structure
- Shared package `watermark_pkg`: state enum (IDLE..DONE), default POLY/SEED constants, and a `misr_fold(sig, d, poly)` function.
- One sub-module, `misr32`:
  - 32-bit register with `load` (SEED), `en` (fold) and `d` input.
  - Async active-low reset to SEED.
  - Instantiated once; the FSM and counter live in the top.

## Test plan
- Reset mid-COLLECT: pull `rst_n` low -> `signature`=FFFFFFFF, `count`=0, `busy`=0 immediately, without waiting for a clock.
- WINDOW=1, `trig_pc`=0, `expected`=FB3EE249; `start`, then retire pc=0, inst=0:
  - -> `signature`=FB3EE249, `done`=1, `match`=1.
- WINDOW=1, `trig_pc`=0, `expected`=0; retire pc=0, inst=8C010004:
  - -> `signature`=773FE24D, `done`=1, `match`=0.
- Trigger gating, WINDOW=1, `trig_pc`=8: retire pc=0 then pc=4 -> stays ARMED, `count`=0; then pc=8 -> folds, `done`.
- WINDOW=4 with `ret_valid` gaps:
  - Four valid retires spread over 10 cycles -> `count` 1..4; `done` exactly 2 edges after the 4th fold.
  - Signature equals the `misr_fold` golden model.
- `start` coincident with `ret_valid` during COLLECT -> retire dropped, `signature`=SEED, `count`=0, state ARMED.
